// File: rtl/riscv_alu.sv
// riscv_alu
//   Integer ALU for the RV32 execute stage. Computes AND/OR/XOR/ADD/SUB/SLT/
//   SLL/SRL/MUL. The result and flags are combinational, so branch and
//   forwarding logic can use them in the same cycle. A registered copy of the
//   result and flags is captured on every clock edge for the EX/MEM boundary.
//
//   Ports
//     clk_i            clock, rising edge
//     rst_ni           async active-low reset (registered outputs only)
//     operand_a_i      operand A (rs1)
//     operand_b_i      operand B (rs2/imm; shift amount in low bits)
//     alu_operation_i  4-bit opcode (alu_op_e)
//     result_o         combinational result
//     zero_flag_o      result_o == 0
//     negative_flag_o  result_o MSB
//     overflow_flag_o  signed overflow of ADD/SUB, else 0
//     result_q_o       result_o registered
//     flags_q_o        {overflow, negative, zero} registered
module riscv_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  input  logic [3:0]            alu_operation_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_flag_o,
  output logic                  negative_flag_o,
  output logic                  overflow_flag_o,
  output logic [DATA_WIDTH-1:0] result_q_o,
  output logic [2:0]            flags_q_o
);

  localparam int SHW = $clog2(DATA_WIDTH);

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_MUL = 4'd7,
    ALU_XOR = 4'd8
  } alu_op_e;

  alu_op_e               op;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] diff;
  logic [DATA_WIDTH-1:0] prod;
  logic [SHW-1:0]        shamt;
  logic                  a_msb;
  logic                  b_msb;
  logic                  slt;

  logic [DATA_WIDTH-1:0] result_d, result_q;
  logic [2:0]            flags_d, flags_q;
  logic                  ovf;

  assign op    = alu_op_e'(alu_operation_i);
  assign a_msb = operand_a_i[DATA_WIDTH-1];
  assign b_msb = operand_b_i[DATA_WIDTH-1];

  // Carry/borrow out is simply dropped: modulo 2^DATA_WIDTH arithmetic.
  assign sum   = operand_a_i + operand_b_i;
  assign diff  = operand_a_i - operand_b_i;
  // Low half of the product is identical for signed and unsigned operands.
  assign prod  = operand_a_i * operand_b_i;
  // Only the low log2(DATA_WIDTH) bits of B select the shift amount.
  assign shamt = operand_b_i[SHW-1:0];
  assign slt   = $signed(operand_a_i) < $signed(operand_b_i);

  always_comb begin
    result_d = '0;
    ovf      = 1'b0;
    case (op)
      ALU_AND: result_d = operand_a_i & operand_b_i;
      ALU_OR:  result_d = operand_a_i | operand_b_i;
      ALU_XOR: result_d = operand_a_i ^ operand_b_i;
      ALU_ADD: begin
        result_d = sum;
        // Same-signed operands producing a result of the other sign.
        ovf      = (a_msb == b_msb) && (sum[DATA_WIDTH-1] != a_msb);
      end
      ALU_SUB: begin
        result_d = diff;
        // Opposite-signed operands where the result sign departs from A.
        ovf      = (a_msb != b_msb) && (diff[DATA_WIDTH-1] != a_msb);
      end
      ALU_SLT: result_d = {{(DATA_WIDTH-1){1'b0}}, slt};
      ALU_SLL: result_d = operand_a_i << shamt;
      ALU_SRL: result_d = operand_a_i >> shamt;
      ALU_MUL: result_d = prod;
      default: begin
        result_d = '0;
        ovf      = 1'b0;
      end
    endcase
  end

  assign result_o        = result_d;
  assign zero_flag_o     = (result_d == '0);
  assign negative_flag_o = result_d[DATA_WIDTH-1];
  assign overflow_flag_o = ovf;

  assign flags_d = {ovf, result_d[DATA_WIDTH-1], (result_d == '0)};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q <= '0;
      flags_q  <= 3'b000;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result_q_o = result_q;
  assign flags_q_o  = flags_q;

endmodule

// File: tb/tb_riscv_alu.sv
// Directed table plus reset/pipeline sequences plus random vectors against an
// independent 64-bit reference model.
module tb_riscv_alu;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] operand_a_i = '0;
  logic [31:0] operand_b_i = '0;
  logic [3:0]  alu_operation_i = '0;
  logic [31:0] result_o;
  logic        zero_flag_o, negative_flag_o, overflow_flag_o;
  logic [31:0] result_q_o;
  logic [2:0]  flags_q_o;

  int checks = 0;
  int failures = 0;

  riscv_alu #(.DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .alu_operation_i(alu_operation_i),
    .result_o(result_o), .zero_flag_o(zero_flag_o),
    .negative_flag_o(negative_flag_o), .overflow_flag_o(overflow_flag_o),
    .result_q_o(result_q_o), .flags_q_o(flags_q_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flg; // {ovf, neg, zero}
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic v, input logic n, input logic z);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.res = res; t.flg = {v, n, z};
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_operation_i = op;
    operand_a_i     = a;
    operand_b_i     = b;
  endtask

  // Reference model: signed math done in 64 bits, overflow from range test.
  task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic [2:0] flg);
    longint sa, sb, wide;
    logic [63:0] p;
    logic v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    v = 1'b0;
    res = 32'h0;
    case (op)
      4'd0: res = a & b;
      4'd1: res = a | b;
      4'd2: begin wide = sa + sb; res = wide[31:0]; v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      4'd3: begin wide = sa - sb; res = wide[31:0]; v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      4'd4: res = (sa < sb) ? 32'd1 : 32'd0;
      4'd5: res = a << (b % 32);
      4'd6: res = a >> (b % 32);
      4'd7: begin p = {32'h0, a} * {32'h0, b}; res = p[31:0]; end
      4'd8: res = a ^ b;
      default: res = 32'h0;
    endcase
    flg = {v, res[31], res == 32'h0};
  endtask

  initial begin
    logic [31:0] er;
    logic [2:0]  ef;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    add_vec(4'd0, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0000FFFF, 0, 0, 0);
    add_vec(4'd0, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 0, 0, 1);
    add_vec(4'd1, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 0, 1, 0);
    add_vec(4'd2, 32'd100,      32'd200,      32'd300,      0, 0, 0);
    add_vec(4'd2, 32'hFFFFFFFF, 32'd1,        32'h00000000, 0, 0, 1);
    add_vec(4'd2, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1, 1, 0);
    add_vec(4'd3, 32'd500,      32'd200,      32'd300,      0, 0, 0);
    add_vec(4'd3, 32'd100,      32'd100,      32'd0,        0, 0, 1);
    add_vec(4'd3, 32'd100,      32'd200,      32'hFFFFFF9C, 0, 1, 0);
    add_vec(4'd3, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1, 0, 0);
    add_vec(4'd4, 32'd10,       32'd20,       32'd1,        0, 0, 0);
    add_vec(4'd4, 32'd20,       32'd10,       32'd0,        0, 0, 1);
    add_vec(4'd4, 32'hFFFFFFFB, 32'd5,        32'd1,        0, 0, 0);
    add_vec(4'd4, 32'd5,        32'hFFFFFFFB, 32'd0,        0, 0, 1);
    add_vec(4'd5, 32'h000000FF, 32'd8,        32'h0000FF00, 0, 0, 0);
    add_vec(4'd6, 32'hFF000000, 32'd8,        32'h00FF0000, 0, 0, 0);
    add_vec(4'd5, 32'd1,        32'd36,       32'h00000010, 0, 0, 0);
    add_vec(4'd6, 32'h80000000, 32'd31,       32'h00000001, 0, 0, 0);
    add_vec(4'd7, 32'd15,       32'd7,        32'd105,      0, 0, 0);
    add_vec(4'd7, 32'd0,        32'd100,      32'd0,        0, 0, 1);
    add_vec(4'd7, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 0, 1, 0);
    add_vec(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 0, 1);
    add_vec(4'd8, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 0, 1, 0);
    add_vec(4'd12, 32'd5,       32'd7,        32'h00000000, 0, 0, 1);
    add_vec(4'd15, 32'h7FFFFFFF, 32'd1,       32'h00000000, 0, 0, 1);

    // Reset state: registered outputs held at zero while rst_ni is low,
    // even across clock edges with nonzero inputs.
    drive(4'd2, 32'd5, 32'd6);
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_result_q", result_q_o, 32'h0);
    chk("reset_flags_q", {29'h0, flags_q_o}, 32'h0);
    chk("reset_comb_result", result_o, 32'd11);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed table: combinational same cycle, registered after one edge.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      chk($sformatf("vec%0d_result", i), result_o, vecs[i].res);
      chk($sformatf("vec%0d_flags", i),
          {29'h0, overflow_flag_o, negative_flag_o, zero_flag_o}, {29'h0, vecs[i].flg});
      @(posedge clk_i);
      #1;
      chk($sformatf("vec%0d_result_q", i), result_q_o, vecs[i].res);
      chk($sformatf("vec%0d_flags_q", i), {29'h0, flags_q_o}, {29'h0, vecs[i].flg});
    end

    // Mid-run asynchronous reset: load a nonzero value, then clear it
    // between edges without any clock.
    @(negedge clk_i);
    drive(4'd2, 32'h7FFFFFFF, 32'd1);
    @(posedge clk_i);
    #1;
    chk("pre_reset_result_q", result_q_o, 32'h80000000);
    chk("pre_reset_flags_q", {29'h0, flags_q_o}, 32'h6);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_reset_result_q", result_q_o, 32'h0);
    chk("async_reset_flags_q", {29'h0, flags_q_o}, 32'h0);
    chk("reset_comb_unaffected", result_o, 32'h80000000);
    chk("reset_comb_ovf_unaffected", {31'h0, overflow_flag_o}, 32'h1);
    @(negedge clk_i);
    drive(4'd2, 32'd1, 32'd2);
    rst_ni = 1'b1;
    #1;
    chk("post_release_no_edge", result_q_o, 32'h0);
    @(posedge clk_i);
    #1;
    chk("post_release_result_q", result_q_o, 32'd3);
    chk("post_release_flags_q", {29'h0, flags_q_o}, 32'h0);

    // Random vectors against the reference model.
    for (int i = 0; i < 1000; i++) begin
      rop = 4'($urandom_range(0, 8));
      ra = $urandom();
      rb = $urandom();
      if (i % 10 == 0) ra = 32'h7FFFFFFF;
      if (i % 10 == 1) ra = 32'h80000000;
      if (i % 10 == 2) rb = 32'h80000000;
      ref_model(rop, ra, rb, er, ef);
      @(negedge clk_i);
      drive(rop, ra, rb);
      #1;
      chk($sformatf("rnd%0d_op%0d_result", i, rop), result_o, er);
      chk($sformatf("rnd%0d_op%0d_flags", i, rop),
          {29'h0, overflow_flag_o, negative_flag_o, zero_flag_o}, {29'h0, ef});
      @(posedge clk_i);
      #1;
      chk($sformatf("rnd%0d_result_q", i), result_q_o, er);
      chk($sformatf("rnd%0d_flags_q", i), {29'h0, flags_q_o}, {29'h0, ef});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
